multu_hilo_unit: RTL and testbench

- Iterative unsigned multiplier with architectural HI/LO registers; sits in the EX stage of the pipelined MIPS core beside the ALU.
- Consumes MULTU operands from the ID/EX register and produces HI/LO for MFHI/MFLO.
- Issues a stall request to the hazard unit while a product is pending, so the pipeline never reads stale HI/LO.

---
 rtl/multu_hilo_unit.sv | 127 ++++++++++++
 tb/tb_multu_hilo_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multu_hilo_unit.sv
// Iterative shift-add unsigned multiplier with architectural HI/LO registers for the EX stage.
// Define MULTU_EARLY_EXIT_EN to commit as soon as the remaining multiplier bits are all zero.
module multu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_rd,
  input  logic             lo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int AW = 2 * WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     upper_sum;
  logic [AW-1:0]      acc_step;
  logic [CNT_W-1:0]   cnt_step;
  logic               commit;
  logic [2*WIDTH-1:0] product;

  // One shift-add iteration: conditionally add the multiplicand into the upper
  // half (carry kept in the extra bit), then shift the whole accumulator right.
  always_comb begin
    upper_sum = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    acc_step  = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
    cnt_step  = cnt_q - 1'b1;
  end

`ifdef MULTU_EARLY_EXIT_EN
  logic          rest_zero;
  logic [AW-1:0] acc_shr;

  // Unconsumed multiplier bits sit in acc_step[cnt_step-1:0]; if all are zero
  // the remaining iterations would only shift, so do that shift in one go.
  always_comb begin
    rest_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (CNT_W'(i) < cnt_step && acc_step[i]) rest_zero = 1'b0;
    end
    acc_shr = acc_step >> cnt_step;
    commit  = rest_zero;
    product = acc_shr[2*WIDTH-1:0];
  end
`else
  always_comb begin
    commit  = (cnt_step == '0);
    product = acc_step[2*WIDTH-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_step;
          if (commit) begin
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (start) begin
            a_d     = op_a;
            acc_d   = {{(WIDTH+1){1'b0}}, op_b};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign stall = busy & (start | hi_rd | lo_rd);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit; expected latencies follow MULTU_EARLY_EXIT_EN when defined.
module tb_multu_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, hi_rd, lo_rd;
  logic [31:0] op_a, op_b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  multu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .hi_rd(hi_rd), .lo_rd(lo_rd),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected commit latency in cycles after the start edge.
  function automatic int lat(input logic [31:0] b);
`ifdef MULTU_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  // Issues one multiply and ends in its DONE cycle.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ph, input logic [31:0] pl,
                         input logic [31:0] eh, input logic [31:0] el, input logic rd);
    int n = lat(b);
    op_a = a; op_b = b; start = 1'b1; lo_rd = rd;
    #1 chk({tag, "_stall_issue"}, 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_done_early"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, {hi, lo}, {ph, pl});
      if (rd) chk({tag, "_stall_busy"}, 64'(stall), 64'd1);
      tick();
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    int pulses;
    int rst_at;
    logic [31:0] b5;
    reset = 1'b0; start = 1'b0; flush = 1'b0; hi_rd = 1'b0; lo_rd = 1'b0;
    op_a = '0; op_b = '0;
    tick(); tick();
    chk("reset_state", {28'd0, busy, done, stall, 3'd0, hi, lo}, 64'd0);
    reset = 1'b1;
    tick();

    // 1: asynchronous reset in the middle of a run
    rst_at = (lat(32'd5) > 10) ? 10 : 1;
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    for (int i = 1; i < rst_at; i++) tick();
    reset = 1'b0;
    #1 chk("t1_async_busy", 64'(busy), 64'd0);
    chk("t1_async_hilo", {hi, lo}, 64'd0);
    tick(); tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("t1_no_done", 64'(pulses), 64'd0);
    chk("t1_hilo", {hi, lo}, 64'd0);

    // 2: 3*5
    do_mult("t2", 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd15, 1'b0);
    tick();
    chk("t2_done_once", 64'(done), 64'd0);

    // 4: 7*9 with MFLO waiting in EX
    do_mult("t4", 32'd7, 32'd9, 32'd0, 32'd15, 32'd0, 32'd63, 1'b1);
    lo_rd = 1'b0;
    tick();
    chk("t4_done_once", 64'(done), 64'd0);

    // 5: flush an in-flight multiply
`ifdef MULTU_EARLY_EXIT_EN
    b5 = 32'h8000_0002;
`else
    b5 = 32'd2;
`endif
    op_a = 32'd2; op_b = b5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("t5_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    chk("t5_quiet", 64'(pulses), 64'd0);
    chk("t5_hilo", {hi, lo}, {32'd0, 32'd63});

    // 3: full-scale operands
    do_mult("t3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd63,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    tick();

    // 6: start and flush together never begins
    op_a = 32'd6; op_b = 32'd6; start = 1'b1; flush = 1'b1;
    #1 chk("t6_stall_same", 64'(stall), 64'd0);
    tick();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    start = 1'b0; flush = 1'b0;
    tick();
    chk("t6_no_done", 64'(done), 64'd0);
    chk("t6_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});

    // 6: back-to-back start from the DONE cycle
    do_mult("t6a", 32'd1, 32'd1, 32'hFFFF_FFFE, 32'h1, 32'd0, 32'd1, 1'b0);
    do_mult("t6b", 32'd4, 32'd4, 32'd0, 32'd1, 32'd0, 32'd16, 1'b0);
    tick();
    chk("t6b_idle", {62'd0, busy, done}, 64'd0);

    reset = 1'b0;
    #1 chk("final_reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
